// File: rtl/qspi_reg_bank_if.sv
// Byte-level link between the quad-SPI receive/transmit pair and the
// register bank: received bytes, transmitter reload handshake, frame end,
// and the QD direction flag.
interface qspi_reg_bank_if;
  logic [7:0] rxdata;
  logic       rxready;
  logic       txready;
  logic       frame_end;
  logic [7:0] txdata;
  logic       writing;

  // Serial front end: delivers bytes and events, consumes tx data
  modport master (
    output rxdata, rxready, txready, frame_end,
    input  txdata, writing
  );

  // Register bank: consumes bytes and events, supplies tx data
  modport slave (
    input  rxdata, rxready, txready, frame_end,
    output txdata, writing
  );
endinterface

// File: rtl/qspi_reg_bank.sv
// Command decoder and auto-incrementing register bank behind the quad-SPI
// slave. The first byte of each chip-select frame is a command; write
// commands store the following bytes, read commands arm the bank to stream
// register contents on the next frame.
// Optional feature macro: QSPI_REG_BANK_STATUS_EN turns the top register
// into a read-only count of completed write frames.
module qspi_reg_bank #(
  parameter int NREGS = 16
) (
  input  logic               clk,
  input  logic               resetn,
  qspi_reg_bank_if.slave     bus,
  output logic [8*NREGS-1:0] regs,
  output logic               wr_pulse,
  output logic               cmd_err
);

  localparam int AW = $clog2(NREGS);

  typedef enum logic [2:0] {S_CMD, S_WR, S_SKIP, S_RDARM, S_RD} state_t;

  state_t          state, state_mid, state_next;
  logic [AW-1:0]   ptr, ptr_mid, ptr_next, tx_ptr;
  logic            wr_en, err_set, err_clr, load_tx;
  logic            writing_q, writing_next;
  logic [7:0]      txdata_q;
  logic [7:0]      mem  [NREGS];
  logic [7:0]      view [NREGS];
  logic            cmd_ok;
`ifdef QSPI_REG_BANK_STATUS_EN
  logic            frame_done;
  logic [7:0]      status_cnt;
`endif

  assign cmd_ok      = (bus.rxdata[6:AW] == '0);
  assign bus.txdata  = txdata_q;
  assign bus.writing = writing_q;

  // Visible bank contents; the status counter replaces the top slot when enabled
  always_comb begin
    for (int i = 0; i < NREGS; i++) view[i] = mem[i];
`ifdef QSPI_REG_BANK_STATUS_EN
    view[NREGS-1] = status_cnt;
`endif
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_flat
    assign regs[8*gi +: 8] = view[gi];
  end

  // Next-state logic: the received byte is handled first, then frame_end acts on the result
  always_comb begin
    state_mid    = state;
    ptr_mid      = ptr;
    wr_en        = 1'b0;
    err_set      = 1'b0;
    err_clr      = 1'b0;
    load_tx      = 1'b0;
    tx_ptr       = ptr;
    writing_next = writing_q;
`ifdef QSPI_REG_BANK_STATUS_EN
    frame_done   = 1'b0;
`endif
    case (state)
      S_CMD: begin
        if (bus.rxready) begin
          if (cmd_ok) begin
            ptr_mid   = bus.rxdata[AW-1:0];
            err_clr   = 1'b1;
            state_mid = bus.rxdata[7] ? S_RDARM : S_WR;
          end else begin
            err_set   = 1'b1;
            state_mid = S_SKIP;
          end
        end
      end
      S_WR: begin
        if (bus.rxready) begin
`ifdef QSPI_REG_BANK_STATUS_EN
          wr_en = (ptr != AW'(NREGS-1));
`else
          wr_en = 1'b1;
`endif
          ptr_mid = ptr + 1'b1;
        end
      end
      S_RD: begin
        if (bus.txready) begin
          load_tx = 1'b1;
          tx_ptr  = ptr;
          ptr_mid = ptr + 1'b1;
        end
      end
      default: ;
    endcase

    state_next = state_mid;
    ptr_next   = ptr_mid;
    if (bus.frame_end) begin
      case (state_mid)
        S_RDARM: begin
          state_next   = S_RD;
          writing_next = 1'b1;
          load_tx      = 1'b1;
          tx_ptr       = ptr_mid;
          ptr_next     = ptr_mid + 1'b1;
        end
        S_RD: begin
          state_next   = S_CMD;
          writing_next = 1'b0;
        end
        S_WR: begin
          state_next = S_CMD;
`ifdef QSPI_REG_BANK_STATUS_EN
          frame_done = 1'b1;
`endif
        end
        default: state_next = S_CMD;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_CMD;
    else         state <= state_next;
  end

  // Pointer, register storage, tx byte and status outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr       <= '0;
      txdata_q  <= '0;
      writing_q <= 1'b0;
      wr_pulse  <= 1'b0;
      cmd_err   <= 1'b0;
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      ptr       <= ptr_next;
      writing_q <= writing_next;
      wr_pulse  <= wr_en;
      if (err_set)      cmd_err <= 1'b1;
      else if (err_clr) cmd_err <= 1'b0;
      if (load_tx) txdata_q <= view[tx_ptr];
      if (wr_en)   mem[ptr] <= bus.rxdata;
    end
  end

`ifdef QSPI_REG_BANK_STATUS_EN
  // Count completed write frames, wrapping at 8 bits
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         status_cnt <= '0;
    else if (frame_done) status_cnt <= status_cnt + 8'd1;
  end
`endif

endmodule

// File: doc/qspi_reg_bank.md
# qspi_reg_bank

Command decoder and register bank sitting directly behind the quad-SPI slave receive/transmit pair. Consumes received bytes (`rxdata`/`rxready`), interprets the first byte of each chip-select frame as a command, and writes following bytes into an auto-incrementing register bank. A read command arms the bank to stream register contents into the transmitter on the next frame via `txdata`/`txready`. Also drives the QD tri-state direction (`writing`).

## Interface
- `NREGS`, 16: number of 8-bit registers; power of two, 2..16.
- `clk`  in  1  system clock; all logic on rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `rxdata`  in  8  received byte; valid when `rxready`.
- `rxready`  in  1  one-`clk` pulse per received byte.
- `txready`  in  1  one-`clk` pulse when transmitter has taken `txdata`.
- `frame_end`  in  1  one-`clk` pulse on synchronised chip-select deassert.
- `txdata`  out  8  next byte for transmitter.
- `writing`  out  1  1 = slave drives QD (read-data frame).
- `regs`  out  8*NREGS  flattened bank; register i at bits [8i+7:8i].
- `wr_pulse`  out  1  one-`clk` pulse per register write.
- `cmd_err`  out  1  sticky flag: last command invalid.

## Operation
- Command byte: bit7 = R (1 read, 0 write); bits[6:log2(NREGS)] must be 0; low log2(NREGS) bits = start address. Nonzero reserved bits → invalid.
- States: CMD, WR, SKIP, RDARM, RD. Reset → CMD.
- CMD, `rxready`: valid write → `ptr`=addr, WR, `cmd_err`=0; valid read → `ptr`=addr, RDARM, `cmd_err`=0; invalid → SKIP, `cmd_err`=1.
- WR, `rxready`: `regs[ptr]`=rxdata, `wr_pulse`=1, `ptr`=ptr+1 mod NREGS (wraps NREGS-1→0).
- SKIP, RDARM: received bytes ignored.
- `frame_end` in CMD/WR/SKIP → CMD. In RDARM → RD, `writing`=1, `txdata`=regs[ptr], `ptr`=ptr+1.
- RD, `txready`: `txdata`=regs[ptr], `ptr`=ptr+1 mod NREGS. `rxready` ignored. `frame_end` → CMD, `writing`=0.
- Simultaneous `rxready` and `frame_end`: byte processed under current state first, then `frame_end` transition applies (e.g. last write byte stored, then CMD; command byte with `frame_end` leaves state CMD or RD per resulting state).
- Empty frame (`frame_end` with no bytes) in CMD: no effect.

## Timing
- Reset values: `txdata`=0, `writing`=0, `regs`=0, `wr_pulse`=0, `cmd_err`=0, `ptr`=0.
- Register write visible on `regs` 1 cycle after `rxready`; `wr_pulse` same cycle.
- `txdata` updated 1 cycle after `txready` or `frame_end` (RDARM→RD); well inside the transmitter's one-QCK-period reload window.
- `writing` changes 1 cycle after `frame_end`.
- Reset mid-frame: all outputs return to reset values immediately; subsequent bytes of that frame treated as new command sequence only after next `frame_end` is not required — first byte after reset is decoded as a command.

## Configuration
- `QSPI_REG_BANK_STATUS_EN` defined: address NREGS-1 is read-only status; reads return count of completed write frames (8-bit, wraps 255→0, counts WR→CMD transitions); writes to it are ignored (no `wr_pulse`), pointer still increments. `regs` slice NREGS-1 shows the counter.
- Undefined: address NREGS-1 is an ordinary read/write register.

## Test plan
- Reset, frame: 0x02, 0xAA, 0x55, `frame_end` → regs[2]=0xAA, regs[3]=0x55, two `wr_pulse`, state CMD.
- Write 0x0E, 0x11, 0x22, 0x33 (NREGS=16, macro off) → regs[14]=0x11, regs[15]=0x22, regs[0]=0x33 (wrap).
- Read: frame 0x82, `frame_end` → `writing`=1, `txdata`=regs[2]; `txready` ×2 → regs[3], regs[4]; `frame_end` → `writing`=0.
- Invalid 0x40, 0x99, `frame_end` → `cmd_err`=1, no register change; next valid 0x00 command → `cmd_err`=0.
- Macro on: three write frames, write 0x0F,0x77 → regs[15] unchanged; read 0x8F → `txdata`=4 (includes the ignored-write frame).
- `rxready` and `frame_end` same cycle on last write byte → byte stored, state CMD; `resetn` low mid-RD → `writing`=0, `txdata`=0 asynchronously.
